// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions: machine word and the fetch-unit state encoding.
package lc3b_types;

  localparam int unsigned WORD_W = 16;

  typedef logic [WORD_W-1:0] lc3b_word;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_REQ     = 2'd1,
    FETCH_HOLD    = 2'd2,
    FETCH_DISCARD = 2'd3
  } lc3b_fetch_state;

  localparam lc3b_word PC_STEP = WORD_W'(2);

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, single-outstanding memory read FSM and a one-entry
// instruction buffer with valid/ready handoff; redirects never abort an in-flight read.
module fetch_unit
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     enable,
  input  logic     redirect,
  input  lc3b_word redirect_pc,
  output lc3b_word mem_address,
  output logic     mem_read,
  input  logic     mem_resp,
  input  lc3b_word mem_rdata,
  output logic     instr_valid,
  output lc3b_word instr,
  output lc3b_word instr_pc,
  input  logic     instr_ready
);

  lc3b_fetch_state r_state;
  lc3b_fetch_state w_state_nxt;
  lc3b_word        r_pc;
  lc3b_word        w_pc_nxt;
  lc3b_word        w_redirect_pc;
  logic            w_capture;
  logic            w_mem_read_nxt;
  logic            w_instr_valid_nxt;
  logic            w_load_addr;

  lc3b_word r_mem_address;
  logic     r_mem_read;
  logic     r_instr_valid;
  lc3b_word r_instr;
  lc3b_word r_instr_pc;

  assign w_redirect_pc = {redirect_pc[WORD_W-1:1], 1'b0};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and PC selection
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_capture   = 1'b0;
    case (r_state)
      FETCH_IDLE: begin
        if (redirect) begin
          w_pc_nxt = w_redirect_pc;
        end else if (enable) begin
          w_state_nxt = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        if (redirect) begin
          w_pc_nxt = w_redirect_pc;
          if (mem_resp) begin
            w_state_nxt = enable ? FETCH_REQ : FETCH_IDLE;
          end else begin
            w_state_nxt = FETCH_DISCARD;
          end
        end else if (mem_resp) begin
          w_capture   = 1'b1;
          w_pc_nxt    = r_pc + PC_STEP;
          w_state_nxt = FETCH_HOLD;
        end
      end
      FETCH_HOLD: begin
        if (instr_ready || redirect) begin
          if (redirect) begin
            w_pc_nxt = w_redirect_pc;
          end
          w_state_nxt = enable ? FETCH_REQ : FETCH_IDLE;
        end
      end
      FETCH_DISCARD: begin
        if (redirect) begin
          w_pc_nxt = w_redirect_pc;
        end
        if (mem_resp) begin
          w_state_nxt = enable ? FETCH_REQ : FETCH_IDLE;
        end
      end
      default: begin
        w_state_nxt = FETCH_IDLE;
      end
    endcase
  end

  // Output decode of the upcoming state so the port flops change with the state
  always_comb begin
    w_mem_read_nxt    = 1'b0;
    w_instr_valid_nxt = 1'b0;
    w_load_addr       = 1'b0;
    case (w_state_nxt)
      FETCH_REQ: begin
        w_mem_read_nxt = 1'b1;
        w_load_addr    = 1'b1;
      end
      FETCH_DISCARD: w_mem_read_nxt    = 1'b1;
      FETCH_HOLD:    w_instr_valid_nxt = 1'b1;
      default:       w_mem_read_nxt    = 1'b0;
    endcase
  end

  // PC, address and instruction buffer registers; address only moves when a read is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_mem_address <= RESET_PC;
      r_mem_read    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
    end else begin
      r_pc          <= w_pc_nxt;
      r_mem_read    <= w_mem_read_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      if (w_load_addr) begin
        r_mem_address <= w_pc_nxt;
      end
      if (w_capture) begin
        r_instr    <= mem_rdata;
        r_instr_pc <= r_pc;
      end
    end
  end

  assign mem_address = r_mem_address;
  assign mem_read    = r_mem_read;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic, all checked
// against a transaction-level model (outstanding read, stale flag, buffered instruction).
`timescale 1ns/1ps
module tb_fetch_unit;
  import lc3b_types::*;

  logic     clk = 1'b0;
  logic     rst_n;
  logic     enable;
  logic     redirect;
  lc3b_word redirect_pc;
  lc3b_word mem_address;
  logic     mem_read;
  logic     mem_resp;
  lc3b_word mem_rdata;
  logic     instr_valid;
  lc3b_word instr;
  lc3b_word instr_pc;
  logic     instr_ready;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .mem_address(mem_address),
    .mem_read   (mem_read),
    .mem_resp   (mem_resp),
    .mem_rdata  (mem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: is a read outstanding, will its data be dropped, is an instruction held
  bit       m_busy;
  bit       m_stale;
  bit       m_have;
  lc3b_word m_pc;
  lc3b_word m_rd_addr;
  lc3b_word m_instr;
  lc3b_word m_instr_pc;

  task automatic model_reset();
    m_busy     = 1'b0;
    m_stale    = 1'b0;
    m_have     = 1'b0;
    m_pc       = 16'h0000;
    m_rd_addr  = 16'h0000;
    m_instr    = 16'h0000;
    m_instr_pc = 16'h0000;
  endtask

  task automatic model_edge();
    bit       launch;
    lc3b_word target;
    launch = 1'b0;
    target = redirect_pc & 16'hFFFE;
    if (m_have) begin
      if (instr_ready || redirect) begin
        m_have = 1'b0;
        if (redirect) m_pc = target;
        launch = enable;
      end
    end else if (m_busy) begin
      if (redirect) m_pc = target;
      if (mem_resp) begin
        m_busy = 1'b0;
        if (!m_stale && !redirect) begin
          m_have     = 1'b1;
          m_instr    = mem_rdata;
          m_instr_pc = m_rd_addr;
          m_pc       = 16'(m_rd_addr + 16'd2);
        end else begin
          launch = enable;
        end
      end else if (redirect) begin
        m_stale = 1'b1;
      end
    end else begin
      if (redirect) m_pc = target;
      else launch = enable;
    end
    if (launch) begin
      m_busy    = 1'b1;
      m_stale   = 1'b0;
      m_rd_addr = m_pc;
    end
  endtask

  task automatic compare_all();
    chk("mem_read", 16'(mem_read), 16'(m_busy));
    chk("mem_address", mem_address, m_rd_addr);
    chk("instr_valid", 16'(instr_valid), 16'(m_have));
    chk("instr", instr, m_instr);
    chk("instr_pc", instr_pc, m_instr_pc);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_mem_read"}, 16'(mem_read), 16'h0000);
    chk({tag, "_instr_valid"}, 16'(instr_valid), 16'h0000);
    chk({tag, "_instr"}, instr, 16'h0000);
    chk({tag, "_instr_pc"}, instr_pc, 16'h0000);
    chk({tag, "_mem_address"}, mem_address, 16'h0000);
  endtask

  // Called at a negedge: drive inputs, clock once, advance the model, compare at next negedge
  task automatic step(input bit en, input bit rd, input lc3b_word rp, input bit rsp,
                      input lc3b_word rdat, input bit rdy);
    enable      = en;
    redirect    = rd;
    redirect_pc = rp;
    mem_resp    = rsp;
    mem_rdata   = rdat;
    instr_ready = rdy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  lc3b_word data;
  lc3b_word held_instr;
  lc3b_word held_pc;
  int       lat;

  initial begin
    rst_n = 1'b0;
    enable = 1'b0; redirect = 1'b0; redirect_pc = '0;
    mem_resp = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    chk("first_req_addr", mem_address, 16'h0000);

    // Sequential fetches with a two-cycle memory, one held in HOLD for five cycles
    for (int k = 0; k < 2; k++) begin
      chk("seq_addr", mem_address, 16'(2 * k));
      step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
      data = 16'($urandom);
      step(1'b1, 1'b0, '0, 1'b1, data, 1'b0);
      chk("seq_valid", 16'(instr_valid), 16'h0001);
      chk("seq_instr", instr, data);
      if (k == 1) begin
        held_instr = instr;
        held_pc    = instr_pc;
        for (int h = 0; h < 5; h++) begin
          step(1'b1, 1'b0, '0, 1'b0, 16'($urandom), 1'b0);
          chk("hold_instr", instr, held_instr);
          chk("hold_pc", instr_pc, held_pc);
          chk("hold_no_read", 16'(mem_read), 16'h0000);
        end
      end
      step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    end

    // Redirect mid-read at 0004: old read finishes, its data is dropped
    chk("pre_redir_addr", mem_address, 16'h0004);
    step(1'b1, 1'b1, 16'h3001, 1'b0, '0, 1'b0);
    chk("discard_read", 16'(mem_read), 16'h0001);
    chk("discard_addr", mem_address, 16'h0004);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    chk("discard_addr2", mem_address, 16'h0004);
    step(1'b1, 1'b0, '0, 1'b1, 16'hDEAD, 1'b0);
    chk("discard_no_valid", 16'(instr_valid), 16'h0000);
    chk("redir_new_addr", mem_address, 16'h3000);

    // Redirect coinciding with mem_resp
    step(1'b1, 1'b1, 16'h5000, 1'b1, 16'hBEEF, 1'b0);
    chk("coincide_no_valid", 16'(instr_valid), 16'h0000);
    chk("coincide_addr", mem_address, 16'h5000);

    // PC wrap from FFFE
    step(1'b1, 1'b1, 16'hFFFE, 1'b1, 16'h1234, 1'b0);
    chk("wrap_req_addr", mem_address, 16'hFFFE);
    step(1'b1, 1'b0, '0, 1'b1, 16'h4321, 1'b0);
    chk("wrap_instr_pc", instr_pc, 16'hFFFE);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    chk("wrap_next_addr", mem_address, 16'h0000);

    // Asynchronous reset in the middle of a read, then a stray response
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    model_reset();
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, '0, 1'b1, 16'hAAAA, 1'b0);
    chk("stray_no_read", 16'(mem_read), 16'h0000);
    chk("stray_no_valid", 16'(instr_valid), 16'h0000);

    // Random traffic against the model
    lat = 0;
    for (int i = 0; i < 3000; i++) begin
      bit en, rd, rsp, rdy;
      en  = ($urandom_range(0, 9) < 8);
      rd  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      rsp = 1'b0;
      if (m_busy) begin
        if (lat == 0) begin
          rsp = 1'b1;
          lat = $urandom_range(0, 3);
        end else begin
          lat--;
        end
      end
      step(en, rd, 16'($urandom), rsp, 16'($urandom), rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 enable  input  1  permits new memory fetches when high.
REQ-005 redirect  input  1  single-cycle strobe replacing the fetch PC.
REQ-006 redirect_pc  input  lc3b_word  new fetch address; bit 0 forced to 0 internally.
REQ-007 mem_address  output  lc3b_word  instruction memory byte address.
REQ-008 mem_read  output  1  read request; level, held until mem_resp.
REQ-009 mem_resp  input  1  one-cycle completion pulse; mem_rdata valid in the same cycle.
REQ-010 mem_rdata  input  lc3b_word  fetched instruction word.
REQ-011 instr_valid  output  1  instr and instr_pc hold a valid instruction.
REQ-012 instr  output  lc3b_word  instruction word for the instruction-register load.
REQ-013 instr_pc  output  lc3b_word  byte address of instr.
REQ-014 instr_ready  input  1  consumer accepts; transfer occurs when instr_valid and instr_ready are both high.

Function
REQ-015 FSM states: IDLE, REQ, HOLD, DISCARD.
REQ-016 IDLE: mem_read=0, instr_valid=0; enable=1 -> REQ next cycle.
REQ-017 REQ: mem_read=1, mem_address=pc, both stable until mem_resp.
REQ-018 REQ with mem_resp and no redirect: capture mem_rdata into instr and pc into instr_pc; pc<=pc+2; -> HOLD.
REQ-019 Latency: instr_valid rises the cycle after mem_resp.
REQ-020 HOLD: instr_valid=1 and instr stable until transfer; on transfer -> REQ if enable=1, else IDLE.
REQ-021 PC arithmetic is modulo 2^16: 16'hFFFE+2 = 16'h0000.
REQ-022 Redirect in IDLE: pc<=redirect_pc; remain in IDLE.
REQ-023 Redirect in REQ with mem_resp in the same cycle: discard mem_rdata; pc<=redirect_pc; remain in REQ with the new address next cycle.
REQ-024 Redirect in REQ without mem_resp: pc<=redirect_pc; -> DISCARD. The in-flight read is never aborted.
REQ-025 DISCARD: mem_read=1 at the old address until mem_resp; data dropped; instr_valid=0; then -> REQ if enable=1, else IDLE.
REQ-026 Redirect during DISCARD: pc<=the latest redirect_pc.
REQ-027 Redirect in HOLD without transfer: instr_valid=0 next cycle; pc<=redirect_pc; -> REQ if enable=1, else IDLE.
REQ-028 Redirect in HOLD coinciding with transfer: the transfer completes; next fetch uses redirect_pc.
REQ-029 enable deasserted in REQ or DISCARD: the outstanding read completes normally; no new read is issued afterwards.
REQ-030 At most one memory read is outstanding at any time.

Reset
REQ-031 Asserting rst_n low immediately forces: state=IDLE, pc=RESET_PC, mem_read=0, instr_valid=0, instr=16'h0000, instr_pc=16'h0000, mem_address=RESET_PC.
REQ-032 Reset asserted during a memory read abandons the read; a mem_resp arriving after reset release in IDLE is ignored.

Structure
REQ-033 lc3b_word is used from the shared lc3b_types package.
REQ-034 The fetch state enum is added to lc3b_types as lc3b_fetch_state.
REQ-035 No sub-modules: a single module containing the FSM, PC register and output buffer.

Verification
REQ-036 Reset, enable=1, memory responds 2 cycles after each request -> reads at 0000, 0002, 0004; instr matches mem_rdata; instr_valid rises the cycle after each mem_resp.
REQ-037 instr_ready held low 5 cycles in HOLD -> instr and instr_pc stable, mem_read=0 throughout.
REQ-038 Redirect to 16'h3001 mid-REQ at 0004 -> mem_read stays high at 0004 until mem_resp; that data is not presented; next read at 3000.
REQ-039 Redirect coinciding with mem_resp -> no instr_valid pulse; next-cycle mem_address equals the redirect target.
REQ-040 pc=FFFE, fetch completes -> instr_pc=FFFE; next read at 0000.
REQ-041 rst_n low in the middle of REQ -> outputs take reset values with no clock edge; a later stray mem_resp is ignored.
